// File: rtl/divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit
// per clock. Results are held until the next completion. A divisor of zero
// short-cuts straight to DONE with q = all-ones, r = dividend.
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quot_r;
  // The partial remainder is always below the divisor between iterations,
  // so WIDTH bits hold it; only the shifted value needs the extra bit.
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   shift_rem_s;
  logic             fits_s;
  logic [WIDTH-1:0] next_rem_s;
  logic [WIDTH-1:0] next_quot_s;

  // One restoring iteration: shift {R,Q} left, trial-subtract the divisor.
  always_comb begin
    shift_rem_s = {rem_r, quot_r[WIDTH-1]};
    fits_s      = (shift_rem_s >= {1'b0, divisor_r});
    next_quot_s = {quot_r[WIDTH-2:0], fits_s};
    if (fits_s) begin
      // The true difference is below the divisor, so the low WIDTH bits are exact.
      next_rem_s = shift_rem_s[WIDTH-1:0] - divisor_r;
    end else begin
      next_rem_s = shift_rem_s[WIDTH-1:0];
    end
  end

  // Control FSM with working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      divisor_r <= {WIDTH{1'b0}};
      quot_r    <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      q         <= {WIDTH{1'b0}};
      r         <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (enable) begin
            divisor_r <= b;
            busy      <= 1'b1;
            if (b != {WIDTH{1'b0}}) begin
              quot_r  <= a;
              rem_r   <= {WIDTH{1'b0}};
              cnt_r   <= CW'(WIDTH - 1);
              state_r <= CALC;
            end else begin
              q        <= {WIDTH{1'b1}};
              r        <= a;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_r  <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          quot_r <= next_quot_s;
          rem_r  <= next_rem_s;
          if (cnt_r == {CW{1'b0}}) begin
            q        <= next_quot_s;
            r        <= next_rem_s;
            div_zero <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/divider.md
# divider

Sequential unsigned integer divider for the 16-bit CPU datapath; the inverse counterpart of the combinational multiplier. It accepts a dividend and divisor on a single-cycle start strobe and computes one quotient bit per cycle using a restoring shift-subtract algorithm. It returns quotient and remainder with a one-cycle completion pulse. The ALU/control unit stalls on `busy` while a division is in flight.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width. The iteration count equals `WIDTH`.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `enable`  input  1  start strobe; sampled only in IDLE
- `a`  input  WIDTH  dividend; sampled on the accepting edge
- `b`  input  WIDTH  divisor; sampled on the accepting edge
- `q`  output  WIDTH  quotient (registered)
- `r`  output  WIDTH  remainder (registered)
- `busy`  output  1  high in CALC and DONE; low only in IDLE
- `done`  output  1  one-cycle pulse; `q`/`r`/`div_zero` are valid from this cycle onward
- `div_zero`  output  1  result flag: the last accepted divisor was 0

One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `enable`=1: latch `b` into divisor reg.
  - If `b`≠0: Q←`a`, R←0 (WIDTH+1 bits), iteration counter←WIDTH-1, go to CALC.
  - If `b`=0: go to DONE directly. Load `q`←all-ones, `r`←`a`, `div_zero`←1.
- CALC, each cycle:
  - Shift {R,Q} left by 1.
  - T = R − divisor, computed WIDTH+1 bits wide.
  - If T ≥ 0: R←T and Q[0]←1. Otherwise Q[0]←0 and R is kept.
  - When the counter reaches 0 on this iteration, load `q`←Q and `r`←R[WIDTH-1:0], clear `div_zero`, and go to DONE. Otherwise decrement the counter.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `enable` in CALC or DONE is ignored. `a`/`b` changes after acceptance have no effect.
- `q`, `r` and `div_zero` hold their last result until the next completion. They are not cleared on acceptance.
- Arithmetic is unsigned only. R never exceeds the divisor − 1 after any iteration. Invariant at completion: a = q·b + r.
- Reset values: `q`=0, `r`=0, `busy`=0, `done`=0, `div_zero`=0; state IDLE.
- Reset priority:
  - `rst` overrides `enable` on the same edge.
  - `rst` during CALC or DONE aborts the operation. No `done` is issued and the partial result is discarded (outputs return to their reset values).

## Timing
- Accepting edge E (IDLE, `enable`=1): `busy`=1 from the cycle after E.
- Normal case:
  - CALC occupies edges E+1 … E+WIDTH (16 iterations).
  - `q`/`r` update at edge E+WIDTH. `done`=1 in the cycle between edges E+WIDTH and E+WIDTH+1.
  - IDLE (`busy`=0) after edge E+WIDTH+1.
  - The earliest next accept is edge E+WIDTH+2. Throughput is one division per WIDTH+2 cycles.
- Divide-by-zero case:
  - DONE is entered at edge E. `done`=1 in the cycle after E.
  - IDLE after edge E+1.
- `done` and `busy` are both high during the DONE cycle.
- `done` is never high for two consecutive cycles.

## Test plan
- Basic division: `a`=100, `b`=7 accepted at edge E. Required: `q`=14, `r`=2, `div_zero`=0, `done` high only in the cycle after edge E+16, `busy` low after edge E+17.
- Boundary values:
  - 0xFFFF/1 → `q`=0xFFFF, `r`=0.
  - 0xFFFF/0xFFFF → `q`=1, `r`=0.
  - 3/10 → `q`=0, `r`=3.
  - 0/5 → `q`=0, `r`=0.
- Divide by zero: `a`=5, `b`=0. Required: `done` in the cycle after E, `q`=0xFFFF, `r`=5, `div_zero`=1. A following 9/3 clears `div_zero` and gives `q`=3, `r`=0.
- Ignored inputs:
  - `enable` pulsed with `a`=1, `b`=1 during CALC of 200/9 → result is still `q`=22, `r`=2, and exactly one `done` pulse.
  - `a`/`b` toggled mid-CALC → result is unchanged.
- Reset mid-operation: `rst` at the 8th CALC edge of 1000/3. Required: from the next cycle `busy`=0, `done`=0, `q`=`r`=0, and no `done` pulse follows. A new 1000/3 then gives `q`=333, `r`=1.
- Random regression: 10k random `a`, nonzero `b`, issued back-to-back at the earliest accept edge. Each result matches `a`/`b` and `a`%`b`, and `done` spacing is exactly 18 cycles.
